// File: rtl/ram_nr_mw_init_pkg.sv
// ram_pkg: shared types and helpers for the multi-port init RAM.
//   ram_state_t : initialisation sequencer states
//   slice_lo()  : low bit of field p in a packed vector of w-bit fields
package ram_pkg;

   typedef enum logic {RAM_INIT, RAM_READY} ram_state_t;

   function automatic int slice_lo(input int p, input int w);
      return p * w;
   endfunction

endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: initialisation sequencer for ram_nr_mw_init.
// Walks init_addr over every entry (one per cycle) after reset or an
// accepted clear request, then raises ready_o.
//   clk, reset (sync, active-high), clear_i (re-init request, READY only)
//   init_we   : 1 while sequencing (array must take INIT_VAL at init_addr)
//   init_addr : entry being initialised
//   ready_o   : 1 once every entry holds INIT_VAL
module ram_init_seq
   import ram_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int INDEX = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   output logic             init_we,
   output logic [INDEX-1:0] init_addr,
   output logic             ready_o
);

   ram_state_t       r_state;
   logic [INDEX-1:0] r_ptr;
   logic             r_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RAM_INIT;
         r_ptr   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            RAM_INIT: begin
               // pointer naturally wraps to 0 on the last entry
               r_ptr <= r_ptr + 1'b1;
               if (r_ptr == INDEX'(DEPTH - 1)) begin
                  r_state <= RAM_READY;
                  r_ready <= 1'b1;
               end
            end
            RAM_READY: begin
               if (clear_i) begin
                  r_state <= RAM_INIT;
                  r_ptr   <= '0;
                  r_ready <= 1'b0;
               end
            end
            default: r_state <= RAM_INIT;
         endcase
      end
   end

   assign init_we   = (r_state == RAM_INIT);
   assign init_addr = r_ptr;
   assign ready_o   = r_ready;

endmodule

// File: rtl/ram_nr_mw_init.sv
// ram_nr_mw_init: RPORT-read / WPORT-write register-file RAM with a
// built-in initialisation sequencer, optional registered read and
// optional write-to-read bypass.
//   clk, reset (sync, active-high), clear_i (re-init request)
//   addr_i / data_o            : packed read addresses / read data
//   addrwr_i / we_i / datawr_i : packed write addresses, enables, data
//   ready_o                    : 1 = initialised, external writes accepted
module ram_nr_mw_init
   import ram_pkg::*;
#(
   parameter int               RPORT    = 2,
   parameter int               WPORT    = 2,
   parameter int               DEPTH    = 64,
   parameter int               INDEX    = 6,
   parameter int               WIDTH    = 32,
   parameter int               RD_LAT   = 0,
   parameter int               BYPASS   = 0,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic [RPORT*INDEX-1:0] addr_i,
   output logic [RPORT*WIDTH-1:0] data_o,
   input  logic [WPORT*INDEX-1:0] addrwr_i,
   input  logic [WPORT-1:0]       we_i,
   input  logic [WPORT*WIDTH-1:0] datawr_i,
   output logic                   ready_o
);

   logic                   w_init_we;
   logic [INDEX-1:0]       w_init_addr;
   logic                   w_rdy;
   logic [RPORT*WIDTH-1:0] w_sel;
   logic [WIDTH-1:0]       r_mem [DEPTH];

   ram_init_seq #(.DEPTH(DEPTH), .INDEX(INDEX)) u_seq (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (clear_i),
      .init_we   (w_init_we),
      .init_addr (w_init_addr),
      .ready_o   (w_rdy)
   );

   assign ready_o = w_rdy;

   // Later ports overwrite earlier ones in the loop, so the highest-indexed
   // port wins on an address collision. A clear edge in READY still writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_init_we) begin
            r_mem[w_init_addr] <= INIT_VAL;
         end else if (w_rdy) begin
            for (int w = 0; w < WPORT; w++) begin
               if (we_i[w])
                  r_mem[addrwr_i[slice_lo(w, INDEX) +: INDEX]] <=
                     datawr_i[slice_lo(w, WIDTH) +: WIDTH];
            end
         end
      end
   end

   // Read selection: array, optionally overridden by the highest matching
   // write port, forced to zero while initialising.
   always_comb begin
      w_sel = '0;
      for (int p = 0; p < RPORT; p++) begin
         w_sel[slice_lo(p, WIDTH) +: WIDTH] = r_mem[addr_i[slice_lo(p, INDEX) +: INDEX]];
         if (BYPASS != 0) begin
            for (int w = 0; w < WPORT; w++) begin
               if (we_i[w] && (addrwr_i[slice_lo(w, INDEX) +: INDEX] ==
                               addr_i[slice_lo(p, INDEX) +: INDEX]))
                  w_sel[slice_lo(p, WIDTH) +: WIDTH] = datawr_i[slice_lo(w, WIDTH) +: WIDTH];
            end
         end
         if (!w_rdy)
            w_sel[slice_lo(p, WIDTH) +: WIDTH] = '0;
      end
   end

   generate
      if (RD_LAT == 1) begin : g_reg
         logic [RPORT*WIDTH-1:0] r_dout;
         always_ff @(posedge clk) begin
            if (reset) r_dout <= '0;
            else       r_dout <= w_sel;
         end
         // mask so the first INIT cycle after a clear does not leak the
         // value captured on the clear edge
         assign data_o = w_rdy ? r_dout : '0;
      end else begin : g_comb
         assign data_o = w_sel;
      end
   endgenerate

endmodule

// File: tb/tb_ram_nr_mw_init.sv
// tb_ram_nr_mw_init: directed self-checking bench. Three instances share
// stimulus: u_c (comb read, no bypass), u_b (comb read, bypass),
// u_r (registered read, no bypass).
module tb_ram_nr_mw_init;

   localparam logic [31:0] IV = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        reset, clear_i;
   logic [11:0] addr_i, addrwr_i;
   logic [1:0]  we_i;
   logic [63:0] datawr_i;
   logic [63:0] d_c, d_b, d_r;
   logic        rdy_c, rdy_b, rdy_r;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_nr_mw_init #(.RD_LAT(0), .BYPASS(0), .INIT_VAL(IV)) u_c (
      .clk(clk), .reset(reset), .clear_i(clear_i), .addr_i(addr_i), .data_o(d_c),
      .addrwr_i(addrwr_i), .we_i(we_i), .datawr_i(datawr_i), .ready_o(rdy_c));
   ram_nr_mw_init #(.RD_LAT(0), .BYPASS(1), .INIT_VAL(IV)) u_b (
      .clk(clk), .reset(reset), .clear_i(clear_i), .addr_i(addr_i), .data_o(d_b),
      .addrwr_i(addrwr_i), .we_i(we_i), .datawr_i(datawr_i), .ready_o(rdy_b));
   ram_nr_mw_init #(.RD_LAT(1), .BYPASS(0), .INIT_VAL(IV)) u_r (
      .clk(clk), .reset(reset), .clear_i(clear_i), .addr_i(addr_i), .data_o(d_r),
      .addrwr_i(addrwr_i), .we_i(we_i), .datawr_i(datawr_i), .ready_o(rdy_r));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // advance one edge, then let things settle off the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rdy(input string tag, input logic exp);
      chk({tag, "_c"}, {31'd0, rdy_c}, {31'd0, exp});
      chk({tag, "_b"}, {31'd0, rdy_b}, {31'd0, exp});
      chk({tag, "_r"}, {31'd0, rdy_r}, {31'd0, exp});
   endtask

   // 64 INIT edges: ready low after edges 1..63, high after edge 64
   task automatic run_init(input string tag);
      for (int i = 1; i <= 64; i++) begin
         step();
         #1;
         if (i == 1 || i == 40 || i == 63) begin
            chk_rdy({tag, "_busy"}, 1'b0);
            chk({tag, "_z_c"}, d_c[31:0], 32'h0);
            chk({tag, "_z_r"}, d_r[31:0], 32'h0);
         end
         if (i == 64) chk_rdy({tag, "_done"}, 1'b1);
      end
   endtask

   initial begin
      reset = 1'b1; clear_i = 1'b0; addr_i = '0; addrwr_i = '0; we_i = '0; datawr_i = '0;
      repeat (3) step();
      #1;
      chk_rdy("rst_rdy", 1'b0);
      chk("rst_d_c", d_c[31:0], 32'h0);
      chk("rst_d_r", d_r[63:32], 32'h0);

      // initialisation timing
      reset = 1'b0;
      run_init("init");

      // every address reads INIT_VAL on both ports
      for (int a = 0; a < 64; a++) begin
         addr_i = {6'(63 - a), 6'(a)};
         #1;
         chk("scan_p0", d_c[31:0], IV);
         chk("scan_p1", d_c[63:32], IV);
      end

      // write conflict: port 1 wins
      we_i = 2'b11; addrwr_i = {6'd5, 6'd5}; datawr_i = {32'h2222, 32'h1111};
      addr_i = {6'd0, 6'd5};
      step();
      we_i = 2'b00;
      #1;
      chk("conflict", d_c[31:0], 32'h2222);

      // bypass vs no bypass, same cycle
      we_i = 2'b01; addrwr_i = {6'd0, 6'd9}; datawr_i = {32'h0, 32'hABCD};
      addr_i = {6'd0, 6'd9};
      #1;
      chk("byp_on", d_b[31:0], 32'hABCD);
      chk("byp_off", d_c[31:0], IV);
      step();
      we_i = 2'b00;
      #1;
      chk("byp_after", d_c[31:0], 32'hABCD);

      // registered read latency
      we_i = 2'b01; addrwr_i = {6'd0, 6'd3}; datawr_i = {32'h0, 32'h77};
      addr_i = {6'd0, 6'd5};
      step();
      we_i = 2'b00;
      addr_i = {6'd3, 6'd5};
      #1;
      chk("rlat_comb", d_c[63:32], 32'h77);
      chk("rlat_t", d_r[63:32], IV);
      step();
      chk("rlat_t1", d_r[63:32], 32'h77);
      chk("rlat_p0", d_r[31:0], 32'h2222);

      // reset mid-INIT at clr_ptr=40 restarts the full sequence
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (40) step();
      #1;
      chk_rdy("mid_busy", 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      run_init("rinit");
      addr_i = {6'd3, 6'd5};
      #1;
      chk("rinit_5", d_c[31:0], IV);
      chk("rinit_3", d_c[63:32], IV);

      // clear request with a same-cycle write
      clear_i = 1'b1; we_i = 2'b01; addrwr_i = {6'd0, 6'd2}; datawr_i = {32'h0, 32'h55};
      addr_i = {6'd0, 6'd2};
      step();
      clear_i = 1'b0;
      // writes issued during INIT must be dropped
      datawr_i = {32'h0, 32'h99};
      #1;
      chk_rdy("clr_rdy", 1'b0);
      run_init("cinit");
      we_i = 2'b00;
      #1;
      chk("clr_ram2", d_c[31:0], IV);
      step();
      chk("clr_ram2_r", d_r[31:0], IV);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0 exp 1");
      $fatal(1);
   end

endmodule
